fpnew_noncomp_wb: RTL and testbench
===================================

// Module: fpnew_noncomp_wb
// PURPOSE
//  Writeback stage directly downstream of the non-computational FP unit.
//  - Takes its result, status, extension bit, class mask, class flag and tag.
//  - Widens the result to OUT_WIDTH: NaN-box, sign-extend or zero-extend.
//  - Accumulates sticky fflags.
//  - Decouples upstream from downstream stalls with a 2-entry skid buffer.
// PARAMETERS
//  WIDTH      32  width of incoming FP result (fp_width of the format)
//  OUT_WIDTH  64  width of formatted writeback data (max(FLEN,XLEN)), >= WIDTH
//  TAG_WIDTH  5   width of tag carried alongside each result
// PORTS
//  clk_i           in   1          clock
//  rst_i           in   1          synchronous reset, active-high
//  in_valid_i      in   1          upstream result valid
//  in_ready_o      out  1          stage can accept a result
//  result_i        in   WIDTH      upstream result
//  status_i        in   5          upstream status {NV,DZ,OF,UF,NX}
//  extension_bit_i in   1          fill value for bits above WIDTH
//  class_mask_i    in   10         classification mask
//  is_class_i      in   1          result is a classification
//  tag_i           in   TAG_WIDTH  tag
//  flush_i         in   1          discard all buffered results
//  out_valid_o     out  1          writeback data valid
//  out_ready_i     in   1          consumer accepts data
//  wb_data_o       out  OUT_WIDTH  formatted writeback data
//  wb_is_int_o     out  1          destination is the integer regfile
//  tag_o           out  TAG_WIDTH  tag of head entry
//  fflags_o        out  5          sticky accumulated status flags
//  fflags_clr_i    in   1          clear sticky flags
//  busy_o          out  1          at least one result buffered
// BEHAVIOUR
//  Formatting (combinational, before the buffer):
//  - is_class_i=1: data = {(OUT_WIDTH-10){0}, class_mask_i}; wb_is_int=1.
//  - Otherwise: data = {(OUT_WIDTH-WIDTH){extension_bit_i}, result_i}.
//  - wb_is_int = ~extension_bit_i | is_class_i (a 1-fill is a NaN-boxed float).
//  - The stored entry is {data, wb_is_int, status, tag}.
//  Buffer FSM with states EMPTY, ONE, TWO:
//  - Entry 0 is the head and drives the outputs, which are registered (no comb path in->out).
//  - in_ready_o = (state!=TWO), registered.
//  - Push = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.
//  - out_valid_o = (state!=EMPTY). busy_o = out_valid_o.
//  - EMPTY: push -> ONE.
//  - ONE: push & !pop -> TWO; pop & !push -> EMPTY; push & pop -> ONE (new entry becomes head).
//  - TWO: pop -> ONE (entry 1 moves to head). No push is possible.
//  - Latency: a result pushed in cycle N is visible on the outputs in cycle N+1.
//  - Throughput: 1/cycle while out_ready_i=1.
//  - Outputs hold stable while out_valid_o=1 & out_ready_i=0.
//  Sticky flags:
//  - On pop, fflags |= head.status.
//  - fflags_clr_i in the same cycle as a pop: fflags = head.status (clear first, then OR).
//  - fflags_clr_i alone: fflags = 0.
//  Flush:
//  - flush_i has priority over push and pop. Next state is EMPTY; in_ready_o=1 next cycle.
//  - Any push that cycle is dropped. fflags are not updated by the dropped head.
//  Reset:
//  - rst_i=1 at a clock edge forces state EMPTY, out_valid_o=0, in_ready_o=1, fflags_o=0, busy_o=0.
//  - wb_data_o, wb_is_int_o and tag_o reset to 0.
//  - Reset mid-transfer drops all entries.
//  - Data registers need no reset beyond the listed outputs.
// TESTING
//  T1 FP passthrough:
//   result=32'h3F80_0000, ext=1, is_class=0, status=0
//   -> next cycle wb_data=64'hFFFF_FFFF_3F80_0000, wb_is_int=0.
//  T2 compare:
//   result=32'h1, ext=0, status=5'b10000
//   -> wb_data=64'h1, wb_is_int=1; after pop fflags_o=5'b10000.
//  T3 classify:
//   is_class=1, class_mask=10'h200
//   -> wb_data=64'h200, wb_is_int=1, fflags unchanged.
//  T4 backpressure:
//   out_ready=0, push tags 3,4
//   -> in_ready_o=0 in cycle after 2nd push, tag_o stays 3.
//   Release out_ready -> tags 3,4 in order, 1 per cycle.
//  T5 flush:
//   TWO entries, flush_i=1 with in_valid_i=1
//   -> next cycle out_valid=0, in_ready=1, fflags unchanged, pushed entry lost.
//  T6 clear vs pop:
//   fflags=5'b00001, pop head with status 5'b00100 and fflags_clr_i=1
//   -> fflags_o=5'b00100.
//   Assert rst_i with entries -> out_valid=0, fflags=0.

Source files
------------

// File: rtl/fpnew_noncomp_wb.sv
// Writeback stage behind the non-computational FP unit: widens results,
// keeps sticky fflags and decouples stalls with a 2-entry skid buffer.
module fpnew_noncomp_wb #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned OUT_WIDTH = 64,
    parameter int unsigned TAG_WIDTH = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     result_i,
    input  logic [4:0]           status_i,
    input  logic                 extension_bit_i,
    input  logic [9:0]           class_mask_i,
    input  logic                 is_class_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [OUT_WIDTH-1:0] wb_data_o,
    output logic                 wb_is_int_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic [4:0]           fflags_o,
    input  logic                 fflags_clr_i,
    output logic                 busy_o
);

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic                 is_int;
        logic [4:0]           status;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e     state_q;
    entry_t     head_q, tail_q, new_entry;
    logic       out_valid_q, in_ready_q;
    logic [4:0] fflags_q;
    logic       push, pop;

    // Classification results go to the integer regfile as a zero-extended mask;
    // a 1-fill marks a NaN-boxed float.
    always_comb begin
        new_entry        = '0;
        new_entry.data   = is_class_i ? {{(OUT_WIDTH-10){1'b0}}, class_mask_i}
                                      : {{(OUT_WIDTH-WIDTH){extension_bit_i}}, result_i};
        new_entry.is_int = ~extension_bit_i | is_class_i;
        new_entry.status = status_i;
        new_entry.tag    = tag_i;
    end

    assign push = in_valid_i & in_ready_q;
    assign pop  = out_valid_q & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fflags_q    <= '0;
            head_q      <= '0;
        end else if (flush_i) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            if (fflags_clr_i) fflags_q <= '0;
        end else begin
            // Clear takes effect before the popped head's status is merged.
            if (pop)               fflags_q <= (fflags_clr_i ? 5'b0 : fflags_q) | head_q.status;
            else if (fflags_clr_i) fflags_q <= '0;

            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_q      <= new_entry;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        tail_q      <= new_entry;
                        state_q     <= TWO;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                    end else if (pop && !push) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else if (push && pop) begin
                        head_q      <= new_entry;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_q      <= tail_q;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = out_valid_q;
    assign wb_data_o   = head_q.data;
    assign wb_is_int_o = head_q.is_int;
    assign tag_o       = head_q.tag;
    assign fflags_o    = fflags_q;

endmodule

// File: tb/tb_fpnew_noncomp_wb.sv
// Directed bench for fpnew_noncomp_wb: formatting, skid buffer, flush,
// sticky flags and reset, with hand-computed expectations.
module tb_fpnew_noncomp_wb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] result_i;
    logic [4:0]  status_i;
    logic        extension_bit_i;
    logic [9:0]  class_mask_i;
    logic        is_class_i;
    logic [4:0]  tag_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] wb_data_o;
    logic        wb_is_int_o;
    logic [4:0]  tag_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i;
    logic        busy_o;

    int total = 0;
    int fails = 0;
    int passed = 0;

    fpnew_noncomp_wb #(.WIDTH(32), .OUT_WIDTH(64), .TAG_WIDTH(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .result_i(result_i), .status_i(status_i),
        .extension_bit_i(extension_bit_i), .class_mask_i(class_mask_i),
        .is_class_i(is_class_i), .tag_i(tag_i), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .wb_data_o(wb_data_o), .wb_is_int_o(wb_is_int_o), .tag_o(tag_o),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] res, input logic ext,
                          input logic cls, input logic [9:0] mask,
                          input logic [4:0] st, input logic [4:0] tg);
        in_valid_i      = v;
        result_i        = res;
        extension_bit_i = ext;
        is_class_i      = cls;
        class_mask_i    = mask;
        status_i        = st;
        tag_i           = tg;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0; fflags_clr_i = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 5'h0, 5'h0);
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_in_ready",  64'(in_ready_o),  64'd1);
        chk("rst_fflags",    64'(fflags_o),    64'd0);
        chk("rst_busy",      64'(busy_o),      64'd0);
        chk("rst_wb_data",   wb_data_o,        64'd0);
        chk("rst_tag",       64'(tag_o),       64'd0);

        // T1 FP passthrough, NaN-boxed
        set_in(1'b1, 32'h3F80_0000, 1'b1, 1'b0, 10'h0, 5'b00000, 5'd1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 5'h0, 5'h0);
        chk("t1_valid",  64'(out_valid_o), 64'd1);
        chk("t1_data",   wb_data_o,        64'hFFFF_FFFF_3F80_0000);
        chk("t1_is_int", 64'(wb_is_int_o), 64'd0);
        chk("t1_tag",    64'(tag_o),       64'd1);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("t1_pop_valid", 64'(out_valid_o), 64'd0);
        chk("t1_fflags",    64'(fflags_o),    64'd0);

        // T2 compare result into integer regfile
        set_in(1'b1, 32'h1, 1'b0, 1'b0, 10'h0, 5'b10000, 5'd2);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 5'h0, 5'h0);
        chk("t2_data",       wb_data_o,        64'h1);
        chk("t2_is_int",     64'(wb_is_int_o), 64'd1);
        chk("t2_fflags_pre", 64'(fflags_o),    64'd0);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("t2_fflags", 64'(fflags_o), 64'b10000);

        // T3 classify (ext=1 must not leak into the upper bits)
        set_in(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 10'h200, 5'b00000, 5'd5);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 5'h0, 5'h0);
        chk("t3_data",   wb_data_o,        64'h200);
        chk("t3_is_int", 64'(wb_is_int_o), 64'd1);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("t3_fflags", 64'(fflags_o), 64'b10000);

        fflags_clr_i = 1'b1;
        tick();
        fflags_clr_i = 1'b0;
        chk("clr_alone", 64'(fflags_o), 64'd0);

        // T4 backpressure then drain
        set_in(1'b1, 32'hA, 1'b0, 1'b0, 10'h0, 5'b00010, 5'd3);
        tick();
        set_in(1'b1, 32'hB, 1'b0, 1'b0, 10'h0, 5'b00001, 5'd4);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 5'h0, 5'h0);
        chk("t4_in_ready_full", 64'(in_ready_o), 64'd0);
        chk("t4_tag_head",      64'(tag_o),      64'd3);
        chk("t4_busy",          64'(busy_o),     64'd1);
        tick();
        chk("t4_tag_hold",  64'(tag_o),   64'd3);
        chk("t4_data_hold", wb_data_o,    64'hA);
        out_ready_i = 1'b1;
        tick();
        chk("t4_tag_second", 64'(tag_o),       64'd4);
        chk("t4_valid_2nd",  64'(out_valid_o), 64'd1);
        chk("t4_data_2nd",   wb_data_o,        64'hB);
        chk("t4_in_ready",   64'(in_ready_o),  64'd1);
        chk("t4_fflags_1",   64'(fflags_o),    64'b00010);
        tick();
        chk("t4_drained",  64'(out_valid_o), 64'd0);
        chk("t4_fflags_2", 64'(fflags_o),    64'b00011);

        // Streaming at 1/cycle: push and pop together in ONE
        set_in(1'b1, 32'h6, 1'b0, 1'b0, 10'h0, 5'b00000, 5'd6);
        tick();
        chk("stream_tag6", 64'(tag_o), 64'd6);
        set_in(1'b1, 32'h7, 1'b0, 1'b0, 10'h0, 5'b00000, 5'd7);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 5'h0, 5'h0);
        chk("stream_tag7",     64'(tag_o),       64'd7);
        chk("stream_valid",    64'(out_valid_o), 64'd1);
        chk("stream_in_ready", 64'(in_ready_o),  64'd1);
        tick();
        out_ready_i = 1'b0;
        chk("stream_done", 64'(out_valid_o), 64'd0);

        // T5 flush from TWO with a pending push and a pop
        set_in(1'b1, 32'h8, 1'b0, 1'b0, 10'h0, 5'b11111, 5'd8);
        tick();
        set_in(1'b1, 32'h9, 1'b0, 1'b0, 10'h0, 5'b11111, 5'd9);
        tick();
        set_in(1'b1, 32'h10, 1'b0, 1'b0, 10'h0, 5'b11111, 5'd10);
        flush_i = 1'b1; out_ready_i = 1'b1;
        tick();
        flush_i = 1'b0; out_ready_i = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 5'h0, 5'h0);
        chk("t5_valid",    64'(out_valid_o), 64'd0);
        chk("t5_in_ready", 64'(in_ready_o),  64'd1);
        chk("t5_fflags",   64'(fflags_o),    64'b00011);
        chk("t5_busy",     64'(busy_o),      64'd0);
        tick();
        chk("t5_lost", 64'(out_valid_o), 64'd0);

        // Flush from ONE drops the push that arrives with it
        set_in(1'b1, 32'h11, 1'b0, 1'b0, 10'h0, 5'b00000, 5'd11);
        tick();
        set_in(1'b1, 32'h12, 1'b0, 1'b0, 10'h0, 5'b00000, 5'd12);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 5'h0, 5'h0);
        chk("flush1_valid", 64'(out_valid_o), 64'd0);
        tick();
        chk("flush1_lost", 64'(out_valid_o), 64'd0);

        // T6 clear in the same cycle as a pop
        fflags_clr_i = 1'b1;
        tick();
        fflags_clr_i = 1'b0;
        set_in(1'b1, 32'h13, 1'b0, 1'b0, 10'h0, 5'b00001, 5'd13);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 5'h0, 5'h0);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("t6_pre", 64'(fflags_o), 64'b00001);
        set_in(1'b1, 32'h14, 1'b0, 1'b0, 10'h0, 5'b00100, 5'd14);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 5'h0, 5'h0);
        out_ready_i = 1'b1; fflags_clr_i = 1'b1;
        tick();
        out_ready_i = 1'b0; fflags_clr_i = 1'b0;
        chk("t6_clr_pop", 64'(fflags_o), 64'b00100);

        // Reset with entries buffered
        set_in(1'b1, 32'h15, 1'b1, 1'b0, 10'h0, 5'b11111, 5'd15);
        tick();
        set_in(1'b1, 32'h16, 1'b1, 1'b0, 10'h0, 5'b11111, 5'd16);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 5'h0, 5'h0);
        chk("pre_rst_full", 64'(in_ready_o), 64'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst2_valid",    64'(out_valid_o), 64'd0);
        chk("rst2_fflags",   64'(fflags_o),    64'd0);
        chk("rst2_in_ready", 64'(in_ready_o),  64'd1);
        chk("rst2_busy",     64'(busy_o),      64'd0);
        chk("rst2_tag",      64'(tag_o),       64'd0);
        tick();
        chk("rst2_stays_empty", 64'(out_valid_o), 64'd0);

        passed = total - fails;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
